unidade_controle: RTL and testbench
===================================

# unidade_controle

Multi-cycle control unit for the 16-bit, eight-register `pratica2` processor. It latches each 9-bit instruction word from `din` and sequences the datapath over 2 or 4 clock cycles. It drives the bus-source selects, the register/A/G load enables and the ALU function, and pulses `done` when the instruction retires. It is a pure sequencer and holds no data besides the instruction register.

## Interface
- `NREG`, default 8: number of general registers. Sets the width of `rout`/`rin`; fixed at 8 by the 3-bit register fields.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: start request; sampled only in state T0.
- `din` in 16: instruction word source; bits [8:0] are captured as IR.
- `ir` out 9: current instruction register, {III, XXX, YYY}.
- `rout` out 8: one-hot, drive register R[i] onto the bus.
- `gout` out 1: drive G onto the bus.
- `dinout` out 1: drive `din` onto the bus.
- `rin` out 8: one-hot, load R[i] from the bus.
- `ain` out 1: load A from the bus.
- `gin` out 1: load G from the ALU.
- `alu_op` out 3: ALU function, equal to III during T2, else 000.
- `done` out 1: one-cycle pulse when the instruction retires.

## Operation
- Opcodes (III):
  - 000 mv Rx←Ry
  - 001 mvi Rx←din
  - 010 add Rx←Rx+Ry
  - 011 sub Rx←Rx−Ry
  - 100 and Rx←Rx&Ry
  - 101 slt Rx←(Rx<Ry signed)?1:0
  - 110 sll Rx←Rx<<Ry[3:0]
  - 111 srl Rx←Rx>>Ry[3:0]
- The ALU arithmetic itself lives in the datapath; this block only sets `alu_op`.
- State register with states T0, T1, T2, T3.
- T0 (fetch/idle):
  - `run`=1: load IR←din[8:0]; next state T1.
  - `run`=0: IR holds; remain in T0.
  - No bus driver, no load enable.
- T1, mv: `rout`[Y]=1, `rin`[X]=1, `done`=1; next T0.
- T1, mvi: `dinout`=1, `rin`[X]=1, `done`=1; next T0. `din` must carry the immediate during this cycle.
- T1, ALU ops (010–111): `rout`[X]=1, `ain`=1; next T2.
- T2: `rout`[Y]=1, `gin`=1, `alu_op`=III; next T3.
- T3: `gout`=1, `rin`[X]=1, `done`=1; next T0.
- All outputs are combinational decodes of state and IR (Moore). Every output not listed for a state is 0.
- Bus rule: at most one of {any `rout` bit, `gout`, `dinout`} is 1 in any cycle. `rin` is never asserted without exactly one bus source.
- X=Y is legal. mv Rx,Rx is a no-op write. add Rx,Rx doubles Rx (A is captured in T1 before G forms in T2).
- IR changes only on a T0 edge with `run`=1. It is stable from T1 through retirement.

## Timing
- Reset (`reset`=1 at a rising edge): state←T0, IR←0 on that edge.
- While `reset` is high, all outputs are forced to 0, including `done` and `alu_op`; `ir` reads 0 after the first edge.
- Reset during T1–T3 aborts the instruction. No `done` is issued and no `rin`/`gin` is asserted in the reset cycle.
- Latency, counted from the T0 edge that accepts `run`:
  - mv/mvi: `done` in the next cycle (2 cycles per instruction).
  - ALU ops: `done` 3 cycles later (4 cycles per instruction).
- `run` held high runs back-to-back instructions. The T0 immediately after `done` accepts the next word with no extra idle cycle.
- `run` toggling during T1–T3 is ignored.
- `done` is exactly one cycle wide and never high in T0 or T2.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `run`=1 and `din`=16'h0049. Required: `ir`=0, state T0, every output 0. Release reset → next edge loads `ir`=9'h049.
- mvi then mv: `din`=9'b001_000_000 then immediate 16'h0005 in T1. Required: T1 `dinout`=1, `rin`=8'h01, `done`=1. Then `din`=9'b000_011_000: T1 `rout`=8'h01, `rin`=8'h08, `done`=1.
- add R1,R2 (`din`=9'b010_001_010):
  - T1: `rout`=8'h02, `ain`=1.
  - T2: `rout`=8'h04, `gin`=1, `alu_op`=3'b010.
  - T3: `gout`=1, `rin`=8'h02, `done`=1.
  - 4 cycles total.
- `run` held high across sub/srl/mv: `done` at cycles 4, 8 and 10. No gap cycles; IR updates only at T0 edges.
- Reset asserted in T2 of an sll: next cycle in T0. No `done`, no `rin` pulse. With `run`=0 the controller stays idle.
- Bus exclusivity: random 9-bit instructions over 10k cycles with random `run` and `reset`. Checker fires if more than one bus source is active, if `rin` is set without a source, or if `done` lasts longer than 1 cycle.

Source files
------------

// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle
// Purpose  : Multi-cycle control unit for the pratica2 processor. Latches a
//            9-bit instruction and sequences the datapath over 2 or 4 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle #(
    parameter int NREG = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [15:0]     din,
    output logic [8:0]      ir,
    output logic [NREG-1:0] rout,
    output logic            gout,
    output logic            dinout,
    output logic [NREG-1:0] rin,
    output logic            ain,
    output logic            gin,
    output logic [2:0]      alu_op,
    output logic            done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0]      c_op_mv  = 3'b000;
    localparam logic [2:0]      c_op_mvi = 3'b001;
    localparam logic [NREG-1:0] c_one    = {{(NREG-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_next;
    logic [8:0]      r_ir;
    logic [2:0]      w_op;
    logic [NREG-1:0] w_xsel;
    logic [NREG-1:0] w_ysel;
    logic            w_unused;

    // Only the low nine bits of din form an instruction; the rest is data.
    assign w_unused = ^din[15:9];

    assign w_op   = r_ir[8:6];
    assign w_xsel = c_one << r_ir[5:3];
    assign w_ysel = c_one << r_ir[2:0];
    assign ir     = r_ir;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= T0;
            r_ir    <= 9'd0;
        end else begin
            r_state <= w_next;
            if (r_state == T0 && run) begin
                r_ir <= din[8:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        rout   = '0;
        gout   = 1'b0;
        dinout = 1'b0;
        rin    = '0;
        ain    = 1'b0;
        gin    = 1'b0;
        alu_op = 3'b000;
        done   = 1'b0;
        case (r_state)
            T0: begin
                if (run) begin
                    w_next = T1;
                end
            end
            T1: begin
                if (w_op == c_op_mv) begin
                    rout   = w_ysel;
                    rin    = w_xsel;
                    done   = 1'b1;
                    w_next = T0;
                end else if (w_op == c_op_mvi) begin
                    dinout = 1'b1;
                    rin    = w_xsel;
                    done   = 1'b1;
                    w_next = T0;
                end else begin
                    rout   = w_xsel;
                    ain    = 1'b1;
                    w_next = T2;
                end
            end
            T2: begin
                rout   = w_ysel;
                gin    = 1'b1;
                alu_op = w_op;
                w_next = T3;
            end
            T3: begin
                gout   = 1'b1;
                rin    = w_xsel;
                done   = 1'b1;
                w_next = T0;
            end
            default: w_next = T0;
        endcase
        // Reset silences every strobe in the same cycle so an aborted
        // instruction never writes a register or retires.
        if (reset) begin
            rout   = '0;
            gout   = 1'b0;
            dinout = 1'b0;
            rin    = '0;
            ain    = 1'b0;
            gin    = 1'b0;
            alu_op = 3'b000;
            done   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_controle
// Purpose  : Scoreboard bench for unidade_controle: directed vectors plus a
//            randomized bus-rule sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_controle;

    typedef struct packed {
        logic [8:0] ir;
        logic [7:0] rout;
        logic       gout;
        logic       dinout;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic [2:0] alu_op;
        logic       done;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic [8:0]  ir;
    logic [7:0]  rout;
    logic        gout;
    logic        dinout;
    logic [7:0]  rin;
    logic        ain;
    logic        gin;
    logic [2:0]  alu_op;
    logic        done;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    started = 0;
    logic  prev_done = 1'b0;

    unidade_controle #(.NREG(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .run    (run),
        .din    (din),
        .ir     (ir),
        .rout   (rout),
        .gout   (gout),
        .dinout (dinout),
        .rin    (rin),
        .ain    (ain),
        .gin    (gin),
        .alu_op (alu_op),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [8:0] i, input logic [7:0] ro,
                                input logic go, input logic di, input logic [7:0] ri,
                                input logic a, input logic g, input logic [2:0] op,
                                input logic d);
        exp_t e;
        e.ir = i; e.rout = ro; e.gout = go; e.dinout = di; e.rin = ri;
        e.ain = a; e.gin = g; e.alu_op = op; e.done = d;
        return e;
    endfunction

    // Apply inputs for one cycle and queue what the outputs must be in it.
    task automatic step(input string nm, input logic rs, input logic rn,
                        input logic [15:0] d, input exp_t e);
        reset = rs;
        run   = rn;
        din   = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t  got;
        exp_t  want;
        string nm;
        int    srcs;
        if (started) begin
            got = {ir, rout, gout, dinout, rin, ain, gin, alu_op, done};
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h", nm, got, want);
                end
            end
            srcs = $countones(rout) + int'(gout) + int'(dinout);
            n_cmp++;
            if (srcs > 1 || (rin != 8'h00 && srcs != 1) || (done && prev_done)) begin
                n_err++;
                $display("FAIL bus_rule: got srcs=%0d rin=%h done=%b prev_done=%b want srcs<=1, rin only with one source, single-cycle done",
                         srcs, rin, done, prev_done);
            end
            prev_done = done;
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        run   = 1'b1;
        din   = 16'h0049;
        @(posedge clock);
        #1;
        started = 1;

        step("reset_hold",  1, 1, 16'h0049, mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("reset_rel",   0, 1, 16'h0049, mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("mvi_r1_t1",   0, 0, 16'h0005, mk(9'h049, 8'h00, 0, 1, 8'h02, 0, 0, 3'd0, 1));
        step("mvi_t0",      0, 1, 16'h0040, mk(9'h049, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("mvi_r0_t1",   0, 0, 16'h0005, mk(9'h040, 8'h00, 0, 1, 8'h01, 0, 0, 3'd0, 1));
        step("mv_t0",       0, 1, 16'h0018, mk(9'h040, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("mv_r3r0_t1",  0, 0, 16'h0000, mk(9'h018, 8'h01, 0, 0, 8'h08, 0, 0, 3'd0, 1));
        step("add_t0",      0, 1, 16'h008A, mk(9'h018, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("add_t1",      0, 0, 16'h0000, mk(9'h08A, 8'h02, 0, 0, 8'h00, 1, 0, 3'd0, 0));
        step("add_t2",      0, 1, 16'h01FF, mk(9'h08A, 8'h04, 0, 0, 8'h00, 0, 1, 3'b010, 0));
        step("add_t3",      0, 0, 16'h0000, mk(9'h08A, 8'h00, 1, 0, 8'h02, 0, 0, 3'd0, 1));
        // run held high: sub R2,R3 / srl R4,R5 / mv R6,R7 back to back
        step("b2b_c1",      0, 1, 16'h00D3, mk(9'h08A, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("sub_t1",      0, 1, 16'h01E5, mk(9'h0D3, 8'h04, 0, 0, 8'h00, 1, 0, 3'd0, 0));
        step("sub_t2",      0, 1, 16'h01E5, mk(9'h0D3, 8'h08, 0, 0, 8'h00, 0, 1, 3'b011, 0));
        step("sub_t3_c4",   0, 1, 16'h01E5, mk(9'h0D3, 8'h00, 1, 0, 8'h04, 0, 0, 3'd0, 1));
        step("b2b_c5",      0, 1, 16'h01E5, mk(9'h0D3, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("srl_t1",      0, 1, 16'h0037, mk(9'h1E5, 8'h10, 0, 0, 8'h00, 1, 0, 3'd0, 0));
        step("srl_t2",      0, 1, 16'h0037, mk(9'h1E5, 8'h20, 0, 0, 8'h00, 0, 1, 3'b111, 0));
        step("srl_t3_c8",   0, 1, 16'h0037, mk(9'h1E5, 8'h00, 1, 0, 8'h10, 0, 0, 3'd0, 1));
        step("b2b_c9",      0, 1, 16'h0037, mk(9'h1E5, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("mv_c10",      0, 0, 16'h0000, mk(9'h037, 8'h80, 0, 0, 8'h40, 0, 0, 3'd0, 1));
        // add R3,R3: X=Y
        step("addxx_t0",    0, 1, 16'h009B, mk(9'h037, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("addxx_t1",    0, 0, 16'h0000, mk(9'h09B, 8'h08, 0, 0, 8'h00, 1, 0, 3'd0, 0));
        step("addxx_t2",    0, 0, 16'h0000, mk(9'h09B, 8'h08, 0, 0, 8'h00, 0, 1, 3'b010, 0));
        step("addxx_t3",    0, 0, 16'h0000, mk(9'h09B, 8'h00, 1, 0, 8'h08, 0, 0, 3'd0, 1));
        // sll R1,R2 aborted by reset in T2
        step("sll_t0",      0, 1, 16'h018A, mk(9'h09B, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("sll_t1",      0, 0, 16'h0000, mk(9'h18A, 8'h02, 0, 0, 8'h00, 1, 0, 3'd0, 0));
        step("sll_rst_t2",  1, 0, 16'h0000, mk(9'h18A, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("idle_1",      0, 0, 16'h018A, mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));
        step("idle_2",      0, 0, 16'h018A, mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 0));

        guard = 0;
        while (exp_q.size() > 0 && guard < 5) begin
            @(posedge clock);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        for (int i = 0; i < 10000; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            run   = 1'($urandom_range(0, 1));
            din   = 16'($urandom());
            @(posedge clock);
            #1;
        end

        reset = 1'b0;
        run   = 1'b0;
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
